// File: rtl/lab2_arith_pkg.sv
// Shared definitions for the Lab2 multi-cycle arithmetic blocks: nibble width,
// sequencer states and nibble-count derivation.
package lab2_arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/lab2_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice; c3_o is the carry into bit 3,
// exported so the caller can form two's-complement overflow.
module lab2_cla4_slice
  import lab2_arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o,
  output logic                c3_o
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is flattened to depend only on g, p and cin_i.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (&p & cin_i);

  assign s_o    = p ^ c[NIBBLE_W-1:0];
  assign cout_o = c[4];
  assign c3_o   = c[3];

endmodule

// File: rtl/lab2_multicycle_cla_adder.sv
// Multi-cycle WIDTH-bit adder: one CLA nibble per clock with a registered carry
// between nibbles. Define CLA_ADDER_OVF_EN to register signed overflow on ovf.
module lab2_multicycle_cla_adder
  import lab2_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         carry_q, carry_d;
  logic                         cout_q, cout_d;
  logic [NIB-1:0][NIBBLE_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;
  logic                slice_c3;
  logic                accept;
  logic                last_step;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_step = (state_q == RUN) && (idx_q == LAST_IDX);

  lab2_cla4_slice u_slice (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout),
    .c3_o   (slice_c3)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_cout;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand and sum registers are plain flops, so they reset with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

`ifdef CLA_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow = carry into MSB xor carry out of MSB, captured on the last nibble.
  always_comb begin
    ovf_d = ovf_q;
    if (accept)         ovf_d = 1'b0;
    else if (last_step) ovf_d = slice_c3 ^ slice_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_terms;
  assign unused_ovf_terms = slice_c3 ^ accept ^ last_step;
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
